// File: rtl/btn_debounce_ctrl.sv
// Bus-mapped button peripheral: 2-FF synchronisers, per-button debounce counters,
// sticky write-1-to-clear press events, and a small read register map for the bridge.
module btn_debounce_ctrl #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  button,
    input  logic [11:0]       addr,
    input  logic              wen,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [N_BTN-1:0]  btn_level,
    output logic              evt_any
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]      WORD_LEVEL = 10'd0;
    localparam logic [9:0]      WORD_EVENT = 10'd1;
    localparam logic [9:0]      WORD_RAW   = 10'd2;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] stable_q;
    logic [N_BTN-1:0] stable_d;
    logic [N_BTN-1:0] evt_q;
    logic [N_BTN-1:0] evt_d;
    logic [N_BTN-1:0] evtSet;
    logic [N_BTN-1:0] evtClr;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic             unusedBits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            evt_q    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= button;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            evt_q    <= evt_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A level is accepted only after it differs from the stable value for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the stable value restarts.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Set has priority over a same-cycle clear so a press is never lost.
    always_comb begin
        evtSet = stable_d & ~stable_q;
        evtClr = '0;
        if (wen && (addr[11:2] == WORD_EVENT)) begin
            evtClr = wdata[N_BTN-1:0];
        end
        evt_d = (evt_q & ~evtClr) | evtSet;
    end

    always_comb begin
        rdata = '0;
        case (addr[11:2])
            WORD_LEVEL: rdata[N_BTN-1:0] = stable_q;
            WORD_EVENT: rdata[N_BTN-1:0] = evt_q;
            WORD_RAW:   rdata[N_BTN-1:0] = sync2_q;
            default:    rdata = '0;
        endcase
    end

    assign btn_level  = stable_q;
    assign evt_any    = |evt_q;
    assign unusedBits = ^{addr[1:0], wdata};

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl with DEBOUNCE_CYCLES=8: reset, press latency,
// bounce rejection, register map, clear/set collision, release and async reset mid-count.
module tb_btn_debounce_ctrl;

    localparam int N_BTN = 5;
    localparam int DEB   = 8;

    typedef struct {
        logic        wen;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] expRdata;
        logic        expEvtAny;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] button;
    logic [11:0]      addr;
    logic             wen;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [N_BTN-1:0] btn_level;
    logic             evt_any;

    int   checkCount = 0;
    int   passCount  = 0;
    vec_t vecs [12];

    btn_debounce_ctrl #(.N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .addr      (addr),
        .wen       (wen),
        .wdata     (wdata),
        .rdata     (rdata),
        .btn_level (btn_level),
        .evt_any   (evt_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 2 ns after each rising edge.
    task automatic stepEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkRead(input string name, input logic [11:0] a, input logic [31:0] expected);
        addr = a;
        #1;
        checkOutput(name, rdata, expected);
        addr = '0;
    endtask

    task automatic applyStimulus(input logic w, input logic [11:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = w;
        stepEdges(1);
        wen   = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    initial begin
        rst    = 1'b1;
        button = 5'b11111;
        addr   = '0;
        wen    = 1'b0;
        wdata  = '0;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,        12'h000, 32'h5, 1'b1};
        vecs[1]  = '{1'b0, 12'h000, 32'h0,        12'h004, 32'h5, 1'b1};
        vecs[2]  = '{1'b0, 12'h000, 32'h0,        12'h008, 32'h5, 1'b1};
        vecs[3]  = '{1'b0, 12'h000, 32'h0,        12'h00C, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 12'h000, 32'h0,        12'h003, 32'h5, 1'b1};
        vecs[5]  = '{1'b0, 12'h000, 32'h0,        12'h006, 32'h5, 1'b1};
        vecs[6]  = '{1'b0, 12'h000, 32'h0,        12'h404, 32'h0, 1'b1};
        vecs[7]  = '{1'b1, 12'h000, 32'hFFFFFFFF, 12'h004, 32'h5, 1'b1};
        vecs[8]  = '{1'b1, 12'h008, 32'hFFFFFFFF, 12'h000, 32'h5, 1'b1};
        vecs[9]  = '{1'b1, 12'h004, 32'hFFFFFFE0, 12'h004, 32'h5, 1'b1};
        vecs[10] = '{1'b1, 12'h00C, 32'hFFFFFFFF, 12'h004, 32'h5, 1'b1};
        vecs[11] = '{1'b1, 12'h004, 32'h00000001, 12'h004, 32'h4, 1'b1};

        // Reset with all buttons held, then release off the clock edge.
        stepEdges(3);
        checkOutput("rst_level", 32'(btn_level), 32'h0);
        checkRead("rst_raw", 12'h008, 32'h0);
        rst = 1'b0;
        checkRead("rel_level_reg", 12'h000, 32'h0);
        checkRead("rel_event_reg", 12'h004, 32'h0);
        checkOutput("rel_evt_any", 32'(evt_any), 32'h0);
        stepEdges(DEB + 1);
        checkOutput("rel_level_edge9", 32'(btn_level), 32'h0);
        stepEdges(1);
        checkOutput("rel_level_edge10", 32'(btn_level), 32'h1F);
        checkRead("rel_events", 12'h004, 32'h1F);
        button = '0;
        stepEdges(DEB + 2);
        checkOutput("all_released", 32'(btn_level), 32'h0);
        checkRead("release_no_evt", 12'h004, 32'h1F);
        applyStimulus(1'b1, 12'h004, 32'h1F);
        checkRead("clear_all", 12'h004, 32'h0);
        checkOutput("clear_all_any", 32'(evt_any), 32'h0);

        // Clean press on button 2.
        button[2] = 1'b1;
        stepEdges(DEB + 1);
        checkOutput("press_edge9", 32'(btn_level), 32'h0);
        stepEdges(1);
        checkOutput("press_edge10", 32'(btn_level), 32'h4);
        checkRead("press_event", 12'h004, 32'h4);
        checkOutput("press_evt_any", 32'(evt_any), 32'h1);
        stepEdges(100);
        checkRead("held_single_evt", 12'h004, 32'h4);

        // Bounce on button 0: pulses shorter than the debounce window are rejected.
        for (int k = 0; k < 4; k++) begin
            button[0] = (k % 2 == 0);
            stepEdges(3);
        end
        checkOutput("bounce_rejected", 32'(btn_level), 32'h4);
        button[0] = 1'b1;
        stepEdges(DEB + 1);
        checkOutput("bounce_edge9", 32'(btn_level), 32'h4);
        stepEdges(1);
        checkOutput("bounce_edge10", 32'(btn_level), 32'h5);
        checkRead("bounce_event", 12'h004, 32'h5);

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].wen, vecs[v].waddr, vecs[v].wdata);
            checkRead($sformatf("vec%0d_rdata", v), vecs[v].raddr, vecs[v].expRdata);
            checkOutput($sformatf("vec%0d_evt_any", v), 32'(evt_any), 32'(vecs[v].expEvtAny));
        end

        // Clear bit 2, release button 2: no event on release.
        applyStimulus(1'b1, 12'h004, 32'h4);
        checkRead("clear_bit2", 12'h004, 32'h0);
        button[2] = 1'b0;
        stepEdges(DEB + 1);
        checkOutput("release_edge9", 32'(btn_level), 32'h5);
        stepEdges(1);
        checkOutput("release_edge10", 32'(btn_level), 32'h1);
        checkRead("release_no_event", 12'h004, 32'h0);
        checkOutput("release_evt_any", 32'(evt_any), 32'h0);

        // Second press of button 2, cleared in the very cycle it qualifies.
        button[2] = 1'b1;
        stepEdges(DEB + 1);
        checkOutput("collide_pre", 32'(btn_level), 32'h1);
        applyStimulus(1'b1, 12'h004, 32'h4);
        checkOutput("collide_level", 32'(btn_level), 32'h5);
        checkRead("collide_set_wins", 12'h004, 32'h4);

        // Press button 1 and hit reset 5 cycles in, off the clock edge.
        button[1] = 1'b1;
        stepEdges(5);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_level", 32'(btn_level), 32'h0);
        checkOutput("arst_evt_any", 32'(evt_any), 32'h0);
        checkRead("arst_event_reg", 12'h004, 32'h0);
        checkRead("arst_raw_reg", 12'h008, 32'h0);
        stepEdges(2);
        rst = 1'b0;
        stepEdges(DEB + 1);
        checkOutput("requal_edge9", 32'(btn_level), 32'h0);
        stepEdges(1);
        checkOutput("requal_edge10", 32'(btn_level), 32'h7);
        checkRead("requal_event", 12'h004, 32'h7);
        checkOutput("requal_evt_any", 32'(evt_any), 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/btn_debounce_ctrl.md
Name: btn_debounce_ctrl

Overview:
Bus-mapped button input peripheral that sits directly upstream of the bridge's button read port (addr_to_btn / rdata_from_btn path).
- Synchronises the raw board buttons into the CPU clock domain and debounces each one independently.
- Latches rising-edge press events into sticky, write-1-to-clear bits.
- Presents debounced level and event registers as 32-bit read data to the bridge, replacing the raw zero-extended button wiring.

Parameters:
N_BTN, 5, number of button inputs (1..32)
DEBOUNCE_CYCLES, 2000000, consecutive stable cycles required to accept a level change (20 ms at 100 MHz); minimum 2
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  peripheral clock (cpu_clk via bridge clk_to_btn)
rst  input  1  reset, asynchronous, active-high
button  input  N_BTN  raw asynchronous button levels from pads, 1 = pressed
addr  input  12  byte offset from bridge (addr_to_btn)
wen  input  1  bus write strobe, valid only for this peripheral's address window
wdata  input  32  bus write data
rdata  output  32  bus read data to bridge (rdata_from_btn)
btn_level  output  N_BTN  debounced button levels
evt_any  output  1  OR of all sticky event bits

Behaviour:
- One clock (clk); rst is asynchronous, active-high; all flops clear immediately on rst assertion.
- Reset values: sync stages 0, stable levels 0, counters 0, events 0; btn_level=0, evt_any=0, rdata=0.
- Synchroniser: 2-FF chain per bit; sync[i] is button[i] delayed by 2 clk edges.
- Debounce, per bit i, every cycle:
  - if sync[i]==stable[i]: cnt[i]<=0
  - else if cnt[i]==DEBOUNCE_CYCLES-1: stable[i]<=sync[i], cnt[i]<=0
  - else cnt[i]<=cnt[i]+1
- A differing level must persist DEBOUNCE_CYCLES consecutive cycles. Any glitch back to the stable value restarts the count from 0.
- Latency from a clean pad edge to a btn_level change: exactly DEBOUNCE_CYCLES+2 clk edges.
- Counter never wraps: it is bounded by the reset-to-0 at DEBOUNCE_CYCLES-1.
- Press event: evt[i] sets on the cycle stable[i] transitions 0->1. Release (1->0) sets no event. Held buttons produce a single event.
- Clear: wen=1 with addr==0x004 clears each evt[i] whose wdata[i]=1. Upper wdata bits above N_BTN are ignored.
- Simultaneous set and clear of the same bit in one cycle: set wins, bit remains 1.
- Writes to any other offset are ignored.
- Register map (read, combinational from registers, zero-extended to 32 bits):
  - 0x000 LEVEL: {zeros, stable}
  - 0x004 EVENT: {zeros, evt}
  - 0x008 RAW: {zeros, sync}
  - any other offset: 32'h0
- Only addr[11:0] is decoded; addr[1:0] are ignored (word access).
- Reads have no side effects; there is no clear-on-read.
- evt_any is registered-derived and combinational OR of evt.
- Reset mid-debounce discards the pending count; the button must then be re-qualified from 0.
- Design target 120-250 lines RTL; no latches, no combinational loops from wdata to rdata.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=8, N_BTN=5.)
1. Reset and read: assert rst with button=5'b11111, then release; read 0x000 and 0x004 -> both 32'h0. btn_level stays 0 until 10 edges after rst deassertion.
2. Clean press: button[2] 0->1 at edge 0 -> btn_level[2]=1 after edge 10, not before. EVENT reads 32'h4, evt_any=1. Hold 100 cycles -> EVENT remains 32'h4 with no second event.
3. Bounce: button[0] toggles 1,0,1,0 every 3 cycles, then holds 1 -> btn_level[0] rises exactly 10 edges after the final 0->1. EVENT bit0 sets once.
4. Clear and collision: EVENT=32'h5, write 0x004 with wdata=32'h1 -> EVENT=32'h4. Then clear bit2 in the same cycle that button[2]'s second press qualifies -> bit2 stays 1.
5. Release and unmapped access: release button[2] -> btn_level[2]=0 after 10 edges, no event set. Read 0x00C -> 32'h0. Write 0x000 with 32'hFFFFFFFF -> no state change.
6. Async reset mid-count: assert rst 5 cycles into a qualifying press (not clock-aligned) -> all outputs 0 immediately. After release with button still held -> full 10-edge requalification, then an event is set.
